dino_vga_timing_ctrl: RTL and testbench
=======================================

// Module: dino_vga_timing_ctrl
// PURPOSE
//  Sequences the dino VGA scanout path. Generates pixel strobe, h/v sync, active-video window and pixel coords.
//  Schedules game-state updates into vertical blanking through a req/ack handshake with the game logic.
//  Sits in the user project area; the renderer consumes x/y/active, and the sync pins drive mprj_io.
// PARAMETERS
//  CLK_DIV   2    clocks per pixel (>=1); pix_stb pulses once every CLK_DIV clocks
//  H_ACTIVE  640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48 (pixels)
//  V_ACTIVE  480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33 (lines)
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//  clock       in   1   system clock
//  resetb      in   1   synchronous reset, active-low
//  enable      in   1   run scanout; low = counters held at 0, syncs deasserted
//  pix_stb     out  1   one-clock pixel strobe
//  hsync       out  1   horizontal sync (level per SYNC_POL)
//  vsync       out  1   vertical sync (level per SYNC_POL)
//  active      out  1   high while hcnt<H_ACTIVE and vcnt<V_ACTIVE
//  x           out  10  hcnt when active, else 0
//  y           out  10  vcnt when active, else 0
//  upd_req     out  1   game may update state (vblank window)
//  upd_ack     in   1   game finished update
//  overrun     out  1   sticky: update not acked before active video resumed
//  frame_cnt   out  16  completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (resetb=0 at posedge): divcnt=hcnt=vcnt=0, pix_stb=0, hsync=vsync=!SYNC_POL, active=0, x=y=0,
//   upd_req=0, overrun=0, frame_cnt=0. Reset mid-frame aborts the frame immediately; no partial upd_req.
//  divcnt counts 0..CLK_DIV-1 while enable; pix_stb=1 when divcnt==CLK_DIV-1 (CLK_DIV=1 -> stb every clock).
//  On pix_stb: hcnt++ ; at H_TOTAL-1 hcnt->0 and vcnt++ ; at vcnt V_TOTAL-1 with hcnt wrap, vcnt->0 and frame_cnt++.
//   H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise.
//  All outputs registered, mutually aligned: they reflect the counter values held during the same cycle.
//  hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt (whole lines).
//  enable low: same as reset except upd_req, overrun and frame_cnt hold. Re-enable starts at hcnt=vcnt=0.
//  Update handshake FSM, states IDLE / REQ / DONE:
//   IDLE->REQ  at the pix_stb where vcnt becomes V_ACTIVE (first blank line, hcnt=0); upd_req=1.
//   REQ->DONE  on upd_ack=1 sampled at posedge; upd_req drops the next cycle.
//   REQ->IDLE  if vcnt wraps to 0 while still in REQ: set overrun=1, drop upd_req.
//   DONE->IDLE at the vcnt wrap to 0. upd_ack is ignored in IDLE/DONE.
//  upd_ack and the wrap in the same cycle: ack wins (no overrun); the FSM still ends in IDLE.
//  overrun is cleared only by reset.
// TESTING (CLK_DIV=1, H 8/2/2/2 -> H_TOTAL 14, V 4/1/1/1 -> V_TOTAL 7, SYNC_POL 0 unless noted)
//  Reset: hold resetb=0 5 clocks with enable=1 -> hsync=vsync=1, active=0, x=y=0, upd_req=0, frame_cnt=0.
//  Timing: run 2 frames -> hsync low exactly at hcnt 10..11 per line, vsync low for line 5 (14 clocks),
//   active high 8 clocks/line on lines 0..3, frame_cnt=2 after 196 clocks.
//  Handshake: ack 3 clocks after upd_req rises -> upd_req high from line 4 hcnt 0 for 4 clocks, overrun stays 0.
//  Overrun: never ack -> upd_req drops at vcnt wrap, overrun=1, held through 3 more frames.
//  Ack on wrap: pulse upd_ack in the cycle vcnt wraps to 0 -> overrun=0.
//  CLK_DIV=3, enable dropped mid-line 2 for 10 clocks -> pix_stb every 3rd clock.
//   On drop: counters zero and syncs deasserted; frame_cnt unchanged; restart at x=0,y=0.

Source files
------------

// File: rtl/dino_vga_timing_ctrl.sv
// VGA scanout timing for the dino game: pixel strobe, syncs, active window, coordinates,
// and a vblank-scheduled update handshake with the game logic.
module dino_vga_timing_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        enable,
  output logic        pix_stb,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        upd_req,
  input  logic        upd_ack,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } upd_state_e;

  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  upd_state_e       state_q, state_d;
  logic             overrun_q, overrun_d;
  logic             pix_stb_q, pix_stb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             upd_req_q, upd_req_d;

  logic stb_s, h_wrap_s, v_wrap_s, enter_blank_s;

  // The registered strobe marks the cycle whose end advances the pixel counters.
  assign stb_s         = enable & pix_stb_q;
  assign h_wrap_s      = stb_s & (hcnt_q == H_LAST);
  assign v_wrap_s      = h_wrap_s & (vcnt_q == V_LAST);
  assign enter_blank_s = h_wrap_s & (vcnt_q == V_ACT_M1);

  // Clock divider, beam counters and frame counter.
  always_comb begin
    divcnt_d    = divcnt_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      divcnt_d = '0;
      hcnt_d   = 10'd0;
      vcnt_d   = 10'd0;
    end else begin
      if (divcnt_q == DIV_LAST) begin
        divcnt_d = '0;
      end else begin
        divcnt_d = divcnt_q + DIV_W'(1);
      end
      if (!stb_s) begin
        hcnt_d = hcnt_q;
      end else if (hcnt_q != H_LAST) begin
        hcnt_d = hcnt_q + 10'd1;
      end else begin
        hcnt_d = 10'd0;
        if (vcnt_q == V_LAST) begin
          vcnt_d      = 10'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end
    end
  end

  // Update handshake: request at the first blank line, release at the frame wrap.
  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (enter_blank_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (upd_ack) begin
          // An ack coinciding with the wrap still counts as on time.
          state_d = v_wrap_s ? ST_IDLE : ST_DONE;
        end else if (v_wrap_s) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        if (v_wrap_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state counters so they line up with the counters once registered.
  always_comb begin
    pix_stb_d = enable & (divcnt_d == DIV_LAST);
    active_d  = enable & (hcnt_d < H_ACT) & (vcnt_d < V_ACT);
    if (enable && (hcnt_d >= HS_START) && (hcnt_d < HS_END)) begin
      hsync_d = SYNC_POL;
    end else begin
      hsync_d = ~SYNC_POL;
    end
    if (enable && (vcnt_d >= VS_START) && (vcnt_d < VS_END)) begin
      vsync_d = SYNC_POL;
    end else begin
      vsync_d = ~SYNC_POL;
    end
    x_d       = active_d ? hcnt_d : 10'd0;
    y_d       = active_d ? vcnt_d : 10'd0;
    upd_req_d = (state_d == ST_REQ);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      divcnt_q    <= '0;
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      frame_cnt_q <= 16'd0;
      state_q     <= ST_IDLE;
      overrun_q   <= 1'b0;
      pix_stb_q   <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      active_q    <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      upd_req_q   <= 1'b0;
    end else begin
      divcnt_q    <= divcnt_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      overrun_q   <= overrun_d;
      pix_stb_q   <= pix_stb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      x_q         <= x_d;
      y_q         <= y_d;
      upd_req_q   <= upd_req_d;
    end
  end

  assign pix_stb   = pix_stb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign active    = active_q;
  assign x         = x_q;
  assign y         = y_q;
  assign upd_req   = upd_req_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dino_vga_timing_ctrl.sv
// Directed bench for dino_vga_timing_ctrl on a small 14x7 raster (CLK_DIV=1 and CLK_DIV=3).
module tb_dino_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb, enable, upd_ack;
  logic        pix_stb, hsync, vsync, active, upd_req, overrun;
  logic [9:0]  x, y;
  logic [15:0] frame_cnt;

  logic        resetb3, enable3, upd_ack3;
  logic        pix_stb3, hsync3, vsync3, active3, upd_req3, overrun3;
  logic [9:0]  x3, y3;
  logic [15:0] frame_cnt3;

  dino_vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut (
    .clock(clk), .resetb(resetb), .enable(enable), .pix_stb(pix_stb),
    .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
    .upd_req(upd_req), .upd_ack(upd_ack), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  dino_vga_timing_ctrl #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_dut3 (
    .clock(clk), .resetb(resetb3), .enable(enable3), .pix_stb(pix_stb3),
    .hsync(hsync3), .vsync(vsync3), .active(active3), .x(x3), .y(y3),
    .upd_req(upd_req3), .upd_ack(upd_ack3), .overrun(overrun3), .frame_cnt(frame_cnt3)
  );

  int n_checks = 0;
  int n_errors = 0;
  // Per-frame ack plan: 0 = ack 3 clocks after request, 1 = never ack, 2 = ack on the wrap cycle.
  int plan [0:7];

  // CLK_DIV=3 reference model state.
  int m_div, m_pix;
  bit m_stb_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, ".stb"},   32'(pix_stb),   32'd0);
    check_val({tag, ".hs"},    32'(hsync),     32'd1);
    check_val({tag, ".vs"},    32'(vsync),     32'd1);
    check_val({tag, ".act"},   32'(active),    32'd0);
    check_val({tag, ".x"},     32'(x),         32'd0);
    check_val({tag, ".y"},     32'(y),         32'd0);
    check_val({tag, ".req"},   32'(upd_req),   32'd0);
    check_val({tag, ".ovr"},   32'(overrun),   32'd0);
    check_val({tag, ".frame"}, 32'(frame_cnt), 32'd0);
  endtask

  // Runs CLK_DIV=1 scanout from reset release; cycle L holds pixel L of the raster.
  task automatic run_main(input int n_cycles);
    int f, p, h, v;
    bit ovr, act, req;
    ovr = 1'b0;
    for (int l = 0; l < n_cycles; l++) begin
      tick();
      f = l / 98;
      p = l % 98;
      h = p % 14;
      v = p / 14;
      if (p == 0 && f > 0 && plan[f-1] == 1) ovr = 1'b1;
      act = (h < 8) && (v < 4);
      req = (p >= 56) && ((plan[f] != 0) || (p <= 59));
      check_val("stb",   32'(pix_stb),   32'd1);
      check_val("act",   32'(active),    32'(act));
      check_val("x",     32'(x),         act ? 32'(h) : 32'd0);
      check_val("y",     32'(y),         act ? 32'(v) : 32'd0);
      check_val("hs",    32'(hsync),     (h == 10 || h == 11) ? 32'd0 : 32'd1);
      check_val("vs",    32'(vsync),     (v == 5) ? 32'd0 : 32'd1);
      check_val("req",   32'(upd_req),   32'(req));
      check_val("ovr",   32'(overrun),   32'(ovr));
      check_val("frame", 32'(frame_cnt), 32'(f));
      upd_ack = (p == 20) || (plan[f] == 0 && (p == 59 || p == 70)) || (plan[f] == 2 && p == 97);
    end
    upd_ack = 1'b0;
  endtask

  // Runs the CLK_DIV=3 instance; the model restarts its divider and pixel count at each call.
  task automatic run_dut3(input int n_cycles, input int base);
    int h, v, f;
    bit stb, act;
    m_div = 0;
    m_pix = 0;
    m_stb_prev = 1'b0;
    for (int k = 0; k < n_cycles; k++) begin
      tick();
      if (m_stb_prev) m_pix++;
      m_div = (m_div + 1) % 3;
      stb = (m_div == 2);
      h = m_pix % 14;
      v = (m_pix / 14) % 7;
      f = base + m_pix / 98;
      act = (h < 8) && (v < 4);
      check_val("d3.stb",   32'(pix_stb3),   32'(stb));
      check_val("d3.act",   32'(active3),    32'(act));
      check_val("d3.x",     32'(x3),         act ? 32'(h) : 32'd0);
      check_val("d3.y",     32'(y3),         act ? 32'(v) : 32'd0);
      check_val("d3.hs",    32'(hsync3),     (h == 10 || h == 11) ? 32'd0 : 32'd1);
      check_val("d3.vs",    32'(vsync3),     (v == 5) ? 32'd0 : 32'd1);
      check_val("d3.frame", 32'(frame_cnt3), 32'(f));
      check_val("d3.ovr",   32'(overrun3),   (f >= 1) ? 32'd1 : 32'd0);
      check_val("d3.req",   32'(upd_req3),   (v >= 4) ? 32'd1 : 32'd0);
      m_stb_prev = stb;
    end
  endtask

  initial begin
    resetb   = 1'b0;
    enable   = 1'b1;
    upd_ack  = 1'b0;
    resetb3  = 1'b0;
    enable3  = 1'b1;
    upd_ack3 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset("rst");
    end

    // Handshake, overrun and its stickiness, then abort mid-request with a reset.
    plan[0] = 0; plan[1] = 1; plan[2] = 0; plan[3] = 0;
    plan[4] = 0; plan[5] = 1; plan[6] = 0; plan[7] = 0;
    resetb = 1'b1;
    run_main(5 * 98 + 70);
    check_val("req_before_mrst", 32'(upd_req), 32'd1);
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset("mrst");
    end

    // Ack landing on the wrap cycle must not flag an overrun.
    plan[0] = 2; plan[1] = 0;
    resetb = 1'b1;
    run_main(98 + 10);

    // CLK_DIV=3: run into line 2 of the second frame, drop enable, then restart.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("d3.rst.stb", 32'(pix_stb3), 32'd0);
      check_val("d3.rst.hs",  32'(hsync3),   32'd1);
    end
    resetb3 = 1'b1;
    run_dut3(400, 0);
    enable3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("d3.off.stb",   32'(pix_stb3),   32'd0);
      check_val("d3.off.act",   32'(active3),    32'd0);
      check_val("d3.off.x",     32'(x3),         32'd0);
      check_val("d3.off.y",     32'(y3),         32'd0);
      check_val("d3.off.hs",    32'(hsync3),     32'd1);
      check_val("d3.off.vs",    32'(vsync3),     32'd1);
      check_val("d3.off.frame", 32'(frame_cnt3), 32'd1);
      check_val("d3.off.ovr",   32'(overrun3),   32'd1);
      check_val("d3.off.req",   32'(upd_req3),   32'd0);
    end
    enable3 = 1'b1;
    run_dut3(60, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
